// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell stepped LSB-first over WIDTH cycles.
// Ports: clk, rst(sync, high), start/sub/op_a/op_b in; busy/done/result/cout/ovf out.

module sa_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_sum_sh;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nx;

  sa_fa_cell u_cell (
    .i_a     (r_a_sh[0]),
    .i_b     (r_b_sh[0]),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_run    = (r_state == S_RUN);
  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = w_run && (r_cnt == CW'(WIDTH - 1));

  // Newest sum bit enters at the MSB; after the final step the
  // oldest (bit 0) sum has reached the LSB of this vector.
  assign w_sum_nx = {w_sum, r_sum_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B, seed the carry with 1.
      r_a_sh   <= op_a;
      r_b_sh   <= sub ? ~op_b : op_b;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= sub;
    end else if (w_run) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_sum_sh <= w_sum_nx[WIDTH-1:1];
      r_carry  <= w_carry;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        // r_carry here is the carry into the MSB.
        r_result <= w_sum_nx;
        r_cout   <= w_carry;
        r_ovf    <= r_carry ^ w_carry;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit vectors, handshake,
// reset abort, plus an exhaustive 4-bit sweep on a second instance.

module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  logic       start4;
  logic       sub4;
  logic [3:0] op_a4;
  logic [3:0] op_b4;
  logic       busy4;
  logic       done4;
  logic [3:0] result4;
  logic       cout4;
  logic       ovf4;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_res;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .sub    (sub4),
    .op_a   (op_a4),
    .op_b   (op_b4),
    .busy   (busy4),
    .done   (done4),
    .result (result4),
    .cout   (cout4),
    .ovf    (ovf4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept an op, walk the 8 RUN cycles, check the DONE cycle.
  // glitch >= 0 pulses start with junk operands at that RUN cycle.
  task automatic run8(input string tag,
                      input logic s,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] er,
                      input logic ec,
                      input logic eo,
                      input int glitch);
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == glitch) begin
        start = 1'b1;
        sub   = ~s;
        op_a  = 8'h55;
        op_b  = 8'h0F;
      end else if (i == glitch + 1) begin
        start = 1'b0;
      end
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_early"}, done, 0);
      chk({tag, "_hold"}, result, last_res);
      tick();
    end
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_nbusy"}, busy, 0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    last_res = er;
  endtask

  task automatic run4(input logic s,
                      input logic [3:0] a,
                      input logic [3:0] b);
    int ua;
    int ub;
    int sa;
    int sb;
    int r;
    int er;
    int ec;
    int eo;
    int early;
    ua = a;
    ub = b;
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    if (s) begin
      er = (ua - ub) & 15;
      ec = (ua >= ub) ? 1 : 0;
      r  = sa - sb;
    end else begin
      er = (ua + ub) & 15;
      ec = (ua + ub > 15) ? 1 : 0;
      r  = sa + sb;
    end
    eo = (r > 7 || r < -8) ? 1 : 0;
    start4 = 1'b1;
    sub4   = s;
    op_a4  = a;
    op_b4  = b;
    tick();
    start4 = 1'b0;
    early  = 0;
    for (int i = 0; i < 4; i++) begin
      if (done4) early++;
      tick();
    end
    chk("w4_early", early, 0);
    chk("w4_done", done4, 1);
    chk("w4_res", result4, er);
    chk("w4_cout", cout4, ec);
    chk("w4_ovf", ovf4, eo);
  endtask

  initial begin
    int seen;
    rst    = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    op_a   = '0;
    op_b   = '0;
    start4 = 1'b0;
    sub4   = 1'b0;
    op_a4  = '0;
    op_b4  = '0;
    last_res = 8'h00;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    run8("add1", 1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, -1);
    tick();
    chk("idle_after", done, 0);
    run8("add2", 1'b0, 8'd127, 8'd1, 8'h80, 1'b0, 1'b1, -1);
    tick();
    run8("add3", 1'b0, 8'd200, 8'd100, 8'd44, 1'b1, 1'b0, -1);
    tick();
    run8("sub1", 1'b1, 8'd5, 8'd7, 8'hFE, 1'b0, 1'b0, -1);
    tick();
    run8("sub2", 1'b1, 8'h80, 8'd1, 8'h7F, 1'b1, 1'b1, -1);
    tick();
    run8("ign", 1'b0, 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 3);
    tick();
    chk("ign_idle", busy, 0);

    // Back-to-back: second start issued in the DONE cycle.
    run8("b2b1", 1'b0, 8'd1, 8'd2, 8'd3, 1'b0, 1'b0, -1);
    run8("b2b2", 1'b1, 8'd9, 8'd4, 8'd5, 1'b1, 1'b0, -1);
    tick();

    // Reset after four bits have been processed.
    start = 1'b1;
    sub   = 1'b0;
    op_a  = 8'd50;
    op_b  = 8'd60;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_nodone", seen, 0);
    last_res = 8'h00;
    run8("post", 1'b0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0, -1);
    tick();

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          run4(s[0], a[3:0], b[3:0]);
        end
      end
    end
    tick();
    chk("w4_idle", busy4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine that time-shares one 1-bit full-adder cell (a, b, cin -> sum, carry) across a WIDTH-bit operation.
- The cell is instantiated exactly once.
- Controller latches operands, steps the cell LSB-first over WIDTH cycles, registers the carry between bits, and returns result and flags through a start/busy/done handshake.
- Sits between a host sequencer and the adder cell.
- Trades area for latency: one cell in place of a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when result and flags are valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- cout  output  1  carry out of MSB; in sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset values (clk edge with rst=1): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal shift regs, bit counter and carry FF = 0.
- Reset has priority over every other input in every state.
- Reset mid-RUN aborts the operation: no done pulse, result cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: load A_sh=op_a, B_sh=(sub ? ~op_b : op_b), carry FF=sub, cnt=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each cycle, cell inputs are a=A_sh[0], b=B_sh[0], cin=carry FF.
  - On the clock edge: cell sum shifts into the result shift register at the MSB, moving right. A_sh and B_sh shift right by 1. Carry FF takes the cell carry. cnt increments.
  - On the cycle with cnt=WIDTH-1:
    - capture carry FF (the carry into the MSB) into c_in_msb;
    - cell carry -> cout;
    - ovf = c_in_msb XOR cell carry;
    - go to DONE.
- DONE (done=1 for exactly this cycle; busy=0):
  - result is fully assembled.
  - start=1: accepted as in IDLE, go directly to RUN (back-to-back, no idle bubble).
  - start=0: go to IDLE.
- Latency: start sampled at edge T -> busy high from T through T+WIDTH -> done high in cycle T+WIDTH, i.e. WIDTH+1 edges after acceptance.
- Throughput: one operation per WIDTH+1 cycles.
- start during RUN: ignored; no queuing; operands and sub not resampled.
- op_a, op_b and sub may change freely after acceptance without effect.
- result, cout and ovf change only at reset or at completion of an operation.
  - They are stale but stable between an accepted start and the next done.
- All arithmetic is modulo 2^WIDTH; there are no saturating modes.
- cnt width is clog2(WIDTH)+1; it never wraps during an operation.

Test Plan:
- WIDTH=8, sub=0, A=100, B=27, start at edge T -> busy high T..T+8; done pulse at cycle T+8; result=127, cout=0, ovf=0.
- sub=0, A=127, B=1 -> result=128 (0x80), cout=0, ovf=1. Then A=200, B=100 -> result=44, cout=1, ovf=0.
- sub=1, A=5, B=7 -> result=254 (0xFE), cout=0 (borrow), ovf=0. Then A=0x80, B=1 -> result=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start again 3 cycles into RUN with different operands -> ignored; first result delivered unchanged at the expected cycle.
  - Assert start in the DONE cycle -> busy rises on the next cycle; second result 9 edges later.
- Reset: assert rst for one cycle mid-RUN (cnt=4) -> next cycle state=IDLE, busy=0, result=0, no done pulse. A following start completes correctly.
- Exhaustive check with WIDTH=4: all 16x16 operand pairs x both sub values, compared against a behavioural model for result, cout and ovf; done exactly once per operation.
